mem_io_bridge: RTL and testbench

//  Parametrised successor to the single-LED/single-switch memory/IO selector. Sits between ALU/controller and

---
 rtl/mem_io_bridge_pkg.sv | 18 +
 rtl/mem_io_bridge_io_addr_decode.sv | 27 ++
 rtl/mem_io_bridge.sv | 183 ++++++++++++++++++
 tb/tb_mem_io_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_bridge_pkg.sv
// Shared types and default parameters for the memory / memory-mapped IO bridge.
package mem_io_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_IO_W       = 16;
  localparam int unsigned DEF_N_IO       = 4;
  localparam int unsigned DEF_STRIDE_LG2 = 4;
  localparam int unsigned DEF_WAIT_CYC   = 1;
  localparam int unsigned DEF_TIMEOUT    = 15;
  localparam logic [31:0] DEF_IO_BASE    = 32'hFFFFFC00;

endpackage

// File: rtl/mem_io_bridge_io_addr_decode.sv
// Combinational IO window decode: window hit, channel index and one-hot chip select.
module io_addr_decode
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned N_IO       = DEF_N_IO,
  parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
  parameter int unsigned STRIDE_LG2 = DEF_STRIDE_LG2
) (
  input  logic [31:0]               addr_in,
  output logic                      hit,
  output logic [$clog2(N_IO)-1:0]   ch,
  output logic [N_IO-1:0]           onehot
);

  localparam int unsigned CH_W = $clog2(N_IO);
  // One extra bit so a window ending exactly at 2^32 cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, IO_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(N_IO) << STRIDE_LG2);

  always_comb begin
    hit         = ({1'b0, addr_in} >= WIN_LO) && ({1'b0, addr_in} < WIN_HI);
    ch          = addr_in[STRIDE_LG2 +: CH_W];
    onehot      = '0;
    onehot[ch]  = 1'b1;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory / IO selector: combinational data-memory path plus a stalled, handshaked
// IO access FSM with wait states, timeout and sign/zero-extended read-back.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned IO_W       = DEF_IO_W,
  parameter int unsigned N_IO       = DEF_N_IO,
  parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
  parameter int unsigned STRIDE_LG2 = DEF_STRIDE_LG2,
  parameter int unsigned WAIT_CYC   = DEF_WAIT_CYC,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_read,
  input  logic                   m_write,
  input  logic                   io_read,
  input  logic                   io_write,
  input  logic                   io_sext,
  input  logic [31:0]            addr_in,
  output logic [31:0]            addr_out,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic [DATA_W-1:0]      r_rdata,
  input  logic [N_IO*IO_W-1:0]   io_rdata,
  input  logic [N_IO-1:0]        io_ready,
  output logic [DATA_W-1:0]      r_wdata,
  output logic [DATA_W-1:0]      write_data,
  output logic [IO_W-1:0]        io_wdata,
  output logic [N_IO-1:0]        io_cs,
  output logic                   io_rd,
  output logic                   io_wr,
  output logic                   stall,
  output logic                   io_err
);

  localparam int unsigned CH_W  = $clog2(N_IO);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic              dec_hit;
  logic [CH_W-1:0]   dec_ch;
  logic [N_IO-1:0]   dec_onehot;
  logic              io_req;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CH_W-1:0]   ch_q,       ch_d;
  logic              wr_q,       wr_d;
  logic              hit_q,      hit_d;
  logic              err_q,      err_d;
  logic              sext_q,     sext_d;
  logic [IO_W-1:0]   io_wdata_q, io_wdata_d;
  logic [N_IO-1:0]   io_cs_q,    io_cs_d;
  logic              io_rd_q,    io_rd_d;
  logic              io_wr_q,    io_wr_d;
  logic [IO_W-1:0]   rd_buf_q,   rd_buf_d;
  logic [DATA_W-1:0] rd_ext;
  logic              wait_met;
  logic              last_try;

  io_addr_decode #(
    .N_IO       (N_IO),
    .IO_BASE    (IO_BASE),
    .STRIDE_LG2 (STRIDE_LG2)
  ) u_decode (
    .addr_in (addr_in),
    .hit     (dec_hit),
    .ch      (dec_ch),
    .onehot  (dec_onehot)
  );

  assign io_req   = io_read | io_write;
  assign addr_out = addr_in;
  assign io_wdata = io_wdata_q;
  assign io_cs    = io_cs_q;
  assign io_rd    = io_rd_q;
  assign io_wr    = io_wr_q;
  assign rd_ext   = {{(DATA_W-IO_W){sext_q & rd_buf_q[IO_W-1]}}, rd_buf_q};
  assign wait_met = 32'(cnt_q) >= WAIT_CYC;
  assign last_try = 32'(cnt_q) == TIMEOUT - 1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    wr_d       = wr_q;
    hit_d      = hit_q;
    err_d      = err_q;
    sext_d     = sext_q;
    io_wdata_d = io_wdata_q;
    io_cs_d    = io_cs_q;
    io_rd_d    = io_rd_q;
    io_wr_d    = io_wr_q;
    rd_buf_d   = rd_buf_q;
    stall      = 1'b0;
    io_err     = 1'b0;
    r_wdata    = '0;
    write_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (io_req) begin
          // IO wins over any memory flag raised in the same cycle; that combination is an error.
          stall      = 1'b1;
          state_d    = ST_ACCESS;
          cnt_d      = '0;
          ch_d       = dec_ch;
          wr_d       = io_write;
          hit_d      = dec_hit;
          err_d      = m_read | m_write | (io_read & io_write);
          sext_d     = io_sext;
          io_wdata_d = r_rdata[IO_W-1:0];
          rd_buf_d   = '0;
          io_cs_d    = dec_hit ? dec_onehot : '0;
          io_rd_d    = dec_hit & ~io_write;
          io_wr_d    = dec_hit & io_write;
        end else begin
          if (m_read)  r_wdata    = m_rdata;
          if (m_write) write_data = r_rdata;
        end
      end

      ST_ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (!hit_q || (wait_met && io_ready[ch_q]) || last_try) begin
          state_d = ST_DONE;
          io_cs_d = '0;
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          if (!hit_q) begin
            err_d = 1'b1;
          end else if (wait_met && io_ready[ch_q]) begin
            if (!wr_q) rd_buf_d = io_rdata[int'(ch_q)*IO_W +: IO_W];
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        io_err  = err_q;
        r_wdata = wr_q ? '0 : rd_ext;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      wr_q       <= 1'b0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      sext_q     <= 1'b0;
      io_wdata_q <= '0;
      io_cs_q    <= '0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      rd_buf_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      wr_q       <= wr_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      sext_q     <= sext_d;
      io_wdata_q <= io_wdata_d;
      io_cs_q    <= io_cs_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: stimulus pushes expected responses, a monitor checks them.
module tb_mem_io_bridge;

  localparam int unsigned WAIT_CYC = 1;
  localparam int unsigned TIMEOUT  = 15;
  localparam logic [31:0] BASE     = 32'hFFFFFC00;
  localparam int unsigned SLOT     = 16;
  localparam int unsigned NCH      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_read, m_write, io_read, io_write, io_sext;
  logic [31:0] addr_in, addr_out, m_rdata, r_rdata, r_wdata, write_data;
  logic [63:0] io_rdata;
  logic [3:0]  io_ready, io_cs;
  logic [15:0] io_wdata;
  logic        io_rd, io_wr, stall, io_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_io;
    logic [31:0] addr;
    logic [31:0] r_wdata;
    logic [31:0] write_data;
    bit          err;
    int          stalls;
    logic [3:0]  cs;
    bit          rd;
    bit          wr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb[$];

  mem_io_bridge #(
    .WAIT_CYC (WAIT_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_read     (m_read),
    .m_write    (m_write),
    .io_read    (io_read),
    .io_write   (io_write),
    .io_sext    (io_sext),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .m_rdata    (m_rdata),
    .r_rdata    (r_rdata),
    .io_rdata   (io_rdata),
    .io_ready   (io_ready),
    .r_wdata    (r_wdata),
    .write_data (write_data),
    .io_wdata   (io_wdata),
    .io_cs      (io_cs),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .stall      (stall),
    .io_err     (io_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory access: one cycle of flags, response expected in that same cycle.
  task automatic mem_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] mdat, input logic [31:0] rdat);
    exp_t e;
    e = '{default: '0};
    e.is_io      = 1'b0;
    e.addr       = addr;
    e.r_wdata    = rd ? mdat : 32'h0;
    e.write_data = wr ? rdat : 32'h0;
    sb.push_back(e);
    @(posedge clk); #1;
    m_read = rd; m_write = wr; addr_in = addr; m_rdata = mdat; r_rdata = rdat;
    @(posedge clk); #1;
    m_read = 1'b0; m_write = 1'b0;
  endtask

  // IO access; ready for the addressed channel rises on ACCESS cycle d (0-based).
  task automatic io_txn(input bit rd, input bit wr, input logic [31:0] addr, input bit sext,
                        input logic [31:0] rdat, input logic [15:0] pdata, input int d,
                        input bit mflag);
    exp_t        e;
    bit          hit;
    int          ch, first_ok, acc;
    bit          ok;
    logic [3:0]  mask;
    logic [63:0] bus;
    hit      = (longint'(addr) >= longint'(BASE)) && (longint'(addr) < longint'(BASE) + NCH * SLOT);
    ch       = hit ? int'((addr - BASE) / SLOT) : 0;
    first_ok = (d > int'(WAIT_CYC)) ? d : int'(WAIT_CYC);
    ok       = hit && (first_ok <= int'(TIMEOUT) - 1);
    acc      = !hit ? 1 : (ok ? first_ok + 1 : int'(TIMEOUT));
    mask     = hit ? 4'(1 << ch) : 4'h0;

    e = '{default: '0};
    e.is_io  = 1'b1;
    e.addr   = addr;
    e.err    = !ok || mflag || (rd && wr);
    e.stalls = 1 + acc;
    e.cs     = mask;
    e.wr     = hit && wr;
    e.rd     = hit && !wr;
    e.wdata  = rdat[15:0];
    if (rd && !wr && ok)
      e.r_wdata = (sext && pdata >= 16'h8000) ? 32'(pdata) + 32'hFFFF0000 : 32'(pdata);
    sb.push_back(e);

    bus = {$urandom, $urandom};
    for (int k = 0; k < int'(NCH); k++)
      if (hit && k == ch) bus[k*16 +: 16] = pdata;

    @(posedge clk); #1;
    io_read = rd; io_write = wr; io_sext = sext; addr_in = addr; r_rdata = rdat;
    io_rdata = bus; io_ready = 4'($urandom) & ~mask;
    if (mflag) begin
      m_read  = $urandom_range(0, 1) == 1;
      m_write = !m_read;
    end
    for (int j = 0; j < acc; j++) begin
      @(posedge clk); #1;
      io_read = 1'b0; io_write = 1'b0; m_read = 1'b0; m_write = 1'b0;
      io_sext = $urandom_range(0, 1) == 1;
      addr_in = $urandom;
      io_ready = (4'($urandom) & ~mask) | ((j >= d) ? mask : 4'h0);
    end
    @(posedge clk); #1;
    io_ready = 4'h0;
    @(posedge clk); #1;
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    int   stall_cnt;
    bit   prev_stall;
    exp_t e;
    stall_cnt  = 0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt  = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (stall) begin
        stall_cnt++;
        if (stall_cnt == 2 && sb.size() > 0) begin
          e = sb[0];
          check("access_cs", 32'(io_cs), 32'(e.cs));
          check("access_rd", 32'(io_rd), 32'(e.rd));
          check("access_wr", 32'(io_wr), 32'(e.wr));
          check("access_wdata", 32'(io_wdata), 32'(e.wdata));
        end
        if (stall_cnt > 64) begin
          check("stall_bound", 32'(stall_cnt), 32'd64);
          stall_cnt = 0;
        end
      end else if (prev_stall) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_is_io", 32'(e.is_io), 32'd1);
          check("done_stalls", 32'(stall_cnt), 32'(e.stalls));
          check("done_r_wdata", r_wdata, e.r_wdata);
          check("done_io_err", 32'(io_err), 32'(e.err));
          check("done_cs", 32'(io_cs), 32'h0);
          check("done_strobes", 32'({io_rd, io_wr}), 32'h0);
          check("done_write_data", write_data, 32'h0);
        end
        stall_cnt = 0;
      end else if ((m_read || m_write) && !io_read && !io_write) begin
        if (sb.size() == 0) begin
          check("unexpected_mem", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("mem_is_mem", 32'(e.is_io), 32'd0);
          check("mem_r_wdata", r_wdata, e.r_wdata);
          check("mem_write_data", write_data, e.write_data);
          check("mem_addr_out", addr_out, e.addr);
          check("mem_io_err", 32'(io_err), 32'd0);
        end
      end else begin
        check("idle_r_wdata", r_wdata, 32'h0);
      end
      prev_stall = stall;
    end
  end

  initial begin
    rst = 1'b1;
    m_read = 0; m_write = 0; io_read = 0; io_write = 0; io_sext = 0;
    addr_in = '0; m_rdata = '0; r_rdata = '0; io_rdata = '0; io_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", 32'(io_cs), 32'h0);
    check("rst_strobes", 32'({io_rd, io_wr}), 32'h0);
    check("rst_wdata", 32'(io_wdata), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_io_err", 32'(io_err), 32'h0);
    rst = 1'b0;

    mem_txn(1'b1, 1'b0, 32'h100, 32'h12345678, 32'h0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC10, 1'b1, 32'h0, 16'h8001, 2, 1'b0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC10, 1'b0, 32'h0, 16'h8001, 2, 1'b0);
    io_txn(1'b0, 1'b1, 32'hFFFFFC30, 1'b0, 32'hABCD5A5A, 16'h0, 2, 1'b0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC20, 1'b1, 32'h0, 16'hFFFF, 1000, 1'b0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC40, 1'b1, 32'h0, 16'h1234, 0, 1'b0);
    io_txn(1'b1, 1'b0, 32'hFFFFFBFF, 1'b0, 32'h0, 16'h1234, 0, 1'b0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC00, 1'b0, 32'h0, 16'h7777, 0, 1'b0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC3F, 1'b1, 32'h0, 16'hC3C3, 14, 1'b0);
    io_txn(1'b1, 1'b1, 32'hFFFFFC24, 1'b0, 32'h11112222, 16'h0, 0, 1'b0);

    // Reset while an access is waiting on a peripheral that never answers.
    @(posedge clk); #1;
    io_read = 1'b1; addr_in = 32'hFFFFFC20; io_ready = 4'h0;
    @(posedge clk); #1;
    io_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_cs", 32'(io_cs), 32'h4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_cs", 32'(io_cs), 32'h0);
    check("post_rst_rd", 32'(io_rd), 32'h0);
    check("post_rst_stall", 32'(stall), 32'h0);
    io_txn(1'b1, 1'b0, 32'hFFFFFC30, 1'b1, 32'h0, 16'h00A5, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        int kind;
        kind = $urandom_range(1, 3);
        mem_txn(kind[0], kind[1], $urandom, $urandom, $urandom);
      end else begin
        int          sel, dl;
        bit          rd, wr;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        rd  = sel != 0 && sel <= 5;
        wr  = sel == 0 || sel > 5;
        if (sel == 9) rd = 1'b1;
        case ($urandom_range(0, 5))
          0:       a = BASE + NCH * SLOT + 32'($urandom_range(0, 64));
          1:       a = BASE - 32'($urandom_range(1, 64));
          default: a = BASE + 32'($urandom_range(0, NCH * SLOT - 1));
        endcase
        dl = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
        io_txn(rd, wr, a, $urandom_range(0, 1) == 1, $urandom, 16'($urandom), dl,
               $urandom_range(0, 9) == 0);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
